// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Booth pair {Q[0], q_m1} encodings; 2'b11 also means no operation.
   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Internal datapath width: one guard bit so -M never overflows.
   function automatic int unsigned ext_width(input int unsigned w);
      return w + 1;
   endfunction

   // Iteration counter width; must hold the value ext_width(w).
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/result handshake bundle of the Booth multiplier.
interface booth_mult_seq_if #(
   parameter int unsigned WIDTH = 8
);

   logic                   start;
   logic                   signed_mode;
   logic [WIDTH-1:0]       multiplicand;
   logic [WIDTH-1:0]       multiplier;
   logic                   ready;
   logic                   busy;
   logic                   done;
   logic [2*WIDTH-1:0]     product;

   // Requester side.
   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  ready, busy, done, product
   );

   // Multiplier side.
   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output ready, busy, done, product
   );

endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift of {A,Q,q_m1}.
module booth_step
   import booth_pkg::*;
#(
   parameter int unsigned E = 9
) (
   input  logic [E-1:0] a,
   input  logic [E-1:0] q,
   input  logic         q_m1,
   input  logic [E-1:0] m,
   output logic [E-1:0] a_next,
   output logic [E-1:0] q_next,
   output logic         q_m1_next
);

   logic [E-1:0] sum;

   // Add/subtract selected by the Booth pair, then shift right keeping A's sign.
   always_comb begin
      sum = a;
      unique case ({q[0], q_m1})
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
      a_next    = {sum[E-1], sum[E-1:1]};
      q_next    = {sum[0], q[E-1:1]};
      q_m1_next = q[0];
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one iteration per clock.
module booth_mult_seq
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
   input  logic            clk,
   input  logic            clr,
   booth_mult_seq_if.slave bus
);

   localparam int unsigned E  = ext_width(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;

   state_t           state_q;
   state_t           state_d;
   logic             accept;
   logic             last_iter;

   logic [E-1:0]     a_q;
   logic [E-1:0]     q_q;
   logic [E-1:0]     m_q;
   logic             q_m1_q;
   logic [CNT_W-1:0] cnt_q;

   logic [E-1:0]     a_n;
   logic [E-1:0]     q_n;
   logic             q_m1_n;

   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic [PW-1:0]    product_q;

   // Sign- or zero-extend an operand to the internal width.
   function automatic logic [E-1:0] extend(input logic [WIDTH-1:0] x, input logic s);
      return {s & x[WIDTH-1], x};
   endfunction

   booth_step #(.E(E)) u_step (
      .a         (a_q),
      .q         (q_q),
      .q_m1      (q_m1_q),
      .m         (m_q),
      .a_next    (a_n),
      .q_next    (q_n),
      .q_m1_next (q_m1_n)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; DONE accepts a new start just like IDLE.
   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      last_iter = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = RUN;
               accept  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d   = DONE;
               last_iter = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (clr) begin
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         ready_q <= (state_d != RUN);
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
      end
   end

   // Operand load on accept, one Booth iteration per RUN cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         a_q    <= '0;
         q_q    <= '0;
         m_q    <= '0;
         q_m1_q <= 1'b0;
         cnt_q  <= '0;
      end else if (accept) begin
         a_q    <= '0;
         q_q    <= extend(bus.multiplier, bus.signed_mode);
         m_q    <= extend(bus.multiplicand, bus.signed_mode);
         q_m1_q <= 1'b0;
         cnt_q  <= CNT_W'(E);
      end else if (state_q == RUN) begin
         a_q    <= a_n;
         q_q    <= q_n;
         q_m1_q <= q_m1_n;
         cnt_q  <= cnt_q - CNT_W'(1);
      end
   end

   // Product register updates only on the completing iteration.
   always_ff @(posedge clk) begin
      if (clr)            product_q <= '0;
      else if (last_iter) product_q <= {a_n[E-3:0], q_n};
   end

   assign bus.ready   = ready_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=8 and WIDTH=13.
module tb_booth_mult_seq;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   booth_mult_seq_if #(.WIDTH(8))  if8 ();
   booth_mult_seq_if #(.WIDTH(13)) if13 ();

   booth_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(if8.slave));
   booth_mult_seq #(.WIDTH(13)) dut13 (.clk(clk), .clr(clr), .bus(if13.slave));

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] q8  [$];
   logic [25:0] q13 [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Exact integer product of the interpreted operands, reduced mod 2^(2w).
   function automatic logic [63:0] ref_prod(input int w, input bit s,
                                            input logic [31:0] a, input logic [31:0] b);
      longint va, vb, p;
      logic [63:0] mask;
      va = longint'({32'd0, a});
      vb = longint'({32'd0, b});
      if (s && a[w-1]) va = va - (longint'(1) << w);
      if (s && b[w-1]) vb = vb - (longint'(1) << w);
      p    = va * vb;
      mask = (64'd1 << (2 * w)) - 64'd1;
      return 64'(p) & mask;
   endfunction

   function automatic logic [31:0] pick(input int w);
      logic [31:0] mask;
      mask = (32'd1 << w) - 32'd1;
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return mask;
         2:       return 32'd1 << (w - 1);
         3:       return (32'd1 << (w - 1)) - 32'd1;
         default: return $urandom() & mask;
      endcase
   endfunction

   // Monitors: every done pops one expected product.
   always @(negedge clk) begin
      if (!clr && if8.done) begin
         if (q8.size() == 0) check("done8_unexpected", 64'(if8.done), 64'd0);
         else                check("product8", 64'(if8.product), 64'(q8.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!clr && if13.done) begin
         if (q13.size() == 0) check("done13_unexpected", 64'(if13.done), 64'd0);
         else                 check("product13", 64'(if13.product), 64'(q13.pop_front()));
      end
   end

   // Called at a negedge; waits for ready, drives one start cycle, returns at the next negedge.
   task automatic issue8(input bit s, input logic [7:0] a, input logic [7:0] b, input bit expect_it);
      int t = 0;
      while (!if8.ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!if8.ready) check("ready8_timeout", 64'(if8.ready), 64'd1);
      if8.signed_mode  = s;
      if8.multiplicand = a;
      if8.multiplier   = b;
      if8.start        = 1'b1;
      if (expect_it) q8.push_back(16'(ref_prod(8, s, 32'(a), 32'(b))));
      @(negedge clk);
      if8.start = 1'b0;
   endtask

   task automatic issue13(input bit s, input logic [12:0] a, input logic [12:0] b);
      int t = 0;
      while (!if13.ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!if13.ready) check("ready13_timeout", 64'(if13.ready), 64'd1);
      if13.signed_mode  = s;
      if13.multiplicand = a;
      if13.multiplier   = b;
      if13.start        = 1'b1;
      q13.push_back(26'(ref_prod(13, s, 32'(a), 32'(b))));
      @(negedge clk);
      if13.start = 1'b0;
   endtask

   task automatic wait_done8();
      int t = 0;
      while (!if8.done && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!if8.done) check("done8_timeout", 64'(if8.done), 64'd1);
   endtask

   // Issue, wait for completion and also check against a hand-derived constant.
   task automatic run8(input string name, input bit s, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] lit);
      issue8(s, a, b, 1'b1);
      wait_done8();
      check(name, 64'(if8.product), 64'(lit));
   endtask

   // Observe a window of negedges starting just after an accept edge.
   task automatic measure8(input int len, output int i_done, output int nbusy, output int ndone);
      i_done = -1;
      nbusy  = 0;
      ndone  = 0;
      for (int i = 0; i < len; i++) begin
         if (if8.busy) nbusy++;
         if (if8.done) begin
            ndone++;
            if (i_done < 0) i_done = i;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int i_done, nbusy, ndone;
      clr = 1'b1;
      if8.start = 1'b0;  if8.signed_mode = 1'b0;  if8.multiplicand = '0;  if8.multiplier = '0;
      if13.start = 1'b0; if13.signed_mode = 1'b0; if13.multiplicand = '0; if13.multiplier = '0;
      repeat (3) @(negedge clk);

      check("rst_ready8",   64'(if8.ready),   64'd1);
      check("rst_busy8",    64'(if8.busy),    64'd0);
      check("rst_done8",    64'(if8.done),    64'd0);
      check("rst_product8", 64'(if8.product), 64'd0);
      check("rst_ready13",  64'(if13.ready),  64'd1);
      check("rst_product13",64'(if13.product),64'd0);
      clr = 1'b0;
      @(negedge clk);

      // 7 x -3: latency and busy length
      issue8(1'b1, 8'h07, 8'hFD, 1'b1);
      measure8(14, i_done, nbusy, ndone);
      check("lat_done_index", 64'(i_done), 64'd9);
      check("lat_busy_cycles", 64'(nbusy), 64'd9);
      check("lat_done_pulses", 64'(ndone), 64'd1);
      check("p_7x-3", 64'(if8.product), 64'h0000_FFEB);

      // Corner operands
      run8("p_-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000);
      run8("p_-128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
      run8("p_255x255",   1'b0, 8'hFF, 8'hFF, 16'hFE01);
      run8("p_0x200",     1'b0, 8'h00, 8'hC8, 16'h0000);
      repeat (3) @(negedge clk);

      // start during RUN is ignored
      issue8(1'b0, 8'd3, 8'd4, 1'b1);
      repeat (2) @(negedge clk);
      if8.multiplicand = 8'd9;
      if8.multiplier   = 8'd9;
      if8.start        = 1'b1;
      @(negedge clk);
      if8.start = 1'b0;
      wait_done8();
      check("p_3x4_midrun", 64'(if8.product), 64'h000C);

      // start in the DONE cycle: back-to-back with no gap
      issue8(1'b1, 8'hF6, 8'd11, 1'b1);
      measure8(12, i_done, nbusy, ndone);
      check("b2b_first_done", 64'(i_done), 64'd9);
      repeat (3) @(negedge clk);
      run8("p_5x-2", 1'b1, 8'd5, 8'hFE, 16'hFFF6);
      issue8(1'b0, 8'd10, 8'd20, 1'b1);
      measure8(14, i_done, nbusy, ndone);
      check("b2b_second_done", 64'(i_done), 64'd9);
      check("p_10x20", 64'(if8.product), 64'd200);

      // clr in iteration 4 aborts 5 x 6
      issue8(1'b0, 8'd5, 8'd6, 1'b0);
      repeat (3) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      check("abort_busy",    64'(if8.busy),    64'd0);
      check("abort_ready",   64'(if8.ready),   64'd1);
      check("abort_done",    64'(if8.done),    64'd0);
      check("abort_product", 64'(if8.product), 64'd0);
      clr = 1'b0;
      measure8(15, i_done, nbusy, ndone);
      check("abort_no_done", 64'(ndone), 64'd0);
      run8("p_5x6_after_abort", 1'b0, 8'd5, 8'd6, 16'h001E);
      repeat (3) @(negedge clk);

      // Random sweep on both widths in parallel
      fork
         begin
            repeat (5000) issue8(1'($urandom_range(0, 1)), 8'(pick(8)), 8'(pick(8)), 1'b1);
         end
         begin
            repeat (5000) issue13(1'($urandom_range(0, 1)), 13'(pick(13)), 13'(pick(13)));
         end
      join

      begin
         int t = 0;
         while ((q8.size() != 0 || q13.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
         end
      end
      check("drain8",  64'(q8.size()),  64'd0);
      check("drain13", 64'(q13.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
